// File: rtl/transaction_record_deframer.sv
// Byte-stream deframer: hunts for a sync byte, gathers a 6-byte payload, verifies
// its XOR checksum and presents the decoded transaction fields over valid/ready.
module transaction_record_deframer #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter int         CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [9:0]       time_stamp,
  output logic             in,
  output logic [1:0]       method_field,
  output logic [29:0]      value,
  output logic             new_wallet,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic             crc_err,
  output logic             timeout_err,
  output logic [CNT_W-1:0] rec_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]    TMO_ONE  = TW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [2:0]      idx_r;
  logic [7:0]      chk_r;
  logic [47:0]     payload_r;
  logic [TW-1:0]   tmo_cnt_r;

  logic accept_s;
  logic in_frame_s;
  logic tmo_hit_s;
  logic chk_ok_s;
  logic byte_ready_d_s;
  logic rec_valid_d_s;
  logic crc_err_d_s;
  logic timeout_err_d_s;
  logic load_fields_s;
  logic rec_inc_s;
  logic err_inc_s;

  assign accept_s   = byte_valid && byte_ready;
  assign in_frame_s = (state_r == ST_PAYLOAD) || (state_r == ST_CHECK);
  // An accepted byte in the limit cycle wins over the timeout.
  assign tmo_hit_s  = in_frame_s && !accept_s && (tmo_cnt_r == TMO_LAST);
  assign chk_ok_s   = (byte_in == chk_r) && (payload_r[47:44] == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_HUNT;
    end else begin
      state_r <= next_state_s;
    end
  end

  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_HUNT: begin
        if (accept_s && (byte_in == SYNC_BYTE)) next_state_s = ST_PAYLOAD;
        else                                    next_state_s = ST_HUNT;
      end
      ST_PAYLOAD: begin
        if (tmo_hit_s)                          next_state_s = ST_HUNT;
        else if (accept_s && (idx_r == 3'd5))   next_state_s = ST_CHECK;
        else                                    next_state_s = ST_PAYLOAD;
      end
      ST_CHECK: begin
        if (tmo_hit_s)                          next_state_s = ST_HUNT;
        else if (accept_s)                      next_state_s = chk_ok_s ? ST_OUTPUT : ST_HUNT;
        else                                    next_state_s = ST_CHECK;
      end
      ST_OUTPUT: begin
        if (rec_valid && rec_ready)             next_state_s = ST_HUNT;
        else                                    next_state_s = ST_OUTPUT;
      end
      default: next_state_s = ST_HUNT;
    endcase
  end

  always_comb begin
    byte_ready_d_s  = (next_state_s != ST_OUTPUT);
    rec_valid_d_s   = (next_state_s == ST_OUTPUT);
    crc_err_d_s     = (state_r == ST_CHECK) && accept_s && !chk_ok_s;
    timeout_err_d_s = tmo_hit_s;
    load_fields_s   = (state_r == ST_CHECK) && accept_s && chk_ok_s;
    rec_inc_s       = (state_r == ST_OUTPUT) && rec_valid && rec_ready;
    err_inc_s       = crc_err_d_s || timeout_err_d_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_ready  <= 1'b0;
      rec_valid   <= 1'b0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      byte_ready  <= byte_ready_d_s;
      rec_valid   <= rec_valid_d_s;
      crc_err     <= crc_err_d_s;
      timeout_err <= timeout_err_d_s;
    end
  end

  // Payload capture, running checksum and inter-byte idle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r     <= 3'd0;
      chk_r     <= 8'd0;
      payload_r <= 48'd0;
      tmo_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_HUNT: begin
          if (accept_s && (byte_in == SYNC_BYTE)) begin
            idx_r     <= 3'd0;
            chk_r     <= 8'd0;
            tmo_cnt_r <= '0;
          end
        end
        ST_PAYLOAD: begin
          if (accept_s) begin
            payload_r[{idx_r, 3'b000} +: 8] <= byte_in;
            chk_r     <= chk_r ^ byte_in;
            idx_r     <= idx_r + 3'd1;
            tmo_cnt_r <= '0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end
        ST_CHECK: begin
          if (accept_s) tmo_cnt_r <= '0;
          else          tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end
        default: begin
          tmo_cnt_r <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_stamp   <= 10'd0;
      in           <= 1'b0;
      method_field <= 2'd0;
      value        <= 30'd0;
      new_wallet   <= 1'b0;
    end else if (load_fields_s) begin
      time_stamp   <= payload_r[9:0];
      in           <= payload_r[10];
      method_field <= payload_r[12:11];
      value        <= payload_r[42:13];
      new_wallet   <= payload_r[43];
    end
  end

  // Saturating record and drop counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_count <= '0;
      err_count <= '0;
    end else begin
      if (rec_inc_s && (rec_count != '1)) rec_count <= rec_count + CNT_ONE;
      if (err_inc_s && (err_count != '1)) err_count <= err_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_transaction_record_deframer.sv
// Self-checking bench for transaction_record_deframer: scenario tasks drive frames,
// a scoreboard queue holds expected records that a monitor checks at each handshake.
module tb_transaction_record_deframer;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [9:0]  time_stamp;
  logic        in_flag;
  logic [1:0]  method_field;
  logic [29:0] value;
  logic        new_wallet;
  logic        rec_valid;
  logic        rec_ready;
  logic        crc_err;
  logic        timeout_err;
  logic [15:0] rec_count;
  logic [15:0] err_count;

  transaction_record_deframer #(
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .time_stamp(time_stamp), .in(in_flag),
    .method_field(method_field), .value(value), .new_wallet(new_wallet),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .crc_err(crc_err),
    .timeout_err(timeout_err), .rec_count(rec_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  ts;
    logic        dir;
    logic [1:0]  m;
    logic [29:0] v;
    logic        nw;
  } rec_t;

  localparam logic [47:0] GOOD_W = 48'h0A468ACF1555;

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   crc_seen = 0;
  int   tmo_seen = 0;
  int   exp_rec = 0;
  int   exp_err = 0;

  function automatic rec_t decode(input logic [47:0] w);
    rec_t r;
    r.ts  = w[9:0];
    r.dir = w[10];
    r.m   = w[12:11];
    r.v   = w[42:13];
    r.nw  = w[43];
    return r;
  endfunction

  function automatic logic [7:0] xsum(input logic [47:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24] ^ w[39:32] ^ w[47:40];
  endfunction

  function automatic logic [79:0] all_outs();
    return {byte_ready, rec_valid, crc_err, timeout_err, time_stamp, in_flag,
            method_field, value, new_wallet, rec_count, err_count};
  endfunction

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (crc_err) crc_seen++;
      if (timeout_err) tmo_seen++;
      if (crc_err || timeout_err) begin
        n_cmp++;
        if (crc_err && timeout_err) begin
          n_fail++;
          $display("FAIL err_exclusive: crc_err=%0b timeout_err=%0b, required not both", crc_err, timeout_err);
        end
      end
      if (rec_valid && rec_ready) begin
        rec_t got;
        rec_t e;
        got = '{ts: time_stamp, dir: in_flag, m: method_field, v: value, nw: new_wallet};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_record: got %h, required no record", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL record_fields: got %h, required %h", got, e);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_fail++;
    $display("FAIL byte_accept_timeout: byte %h not accepted in 50 cycles, required acceptance", b);
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] w, input logic [7:0] ck);
    if (ck == xsum(w) && w[47:44] == 4'd0) begin
      exp_q.push_back(decode(w));
      exp_rec++;
    end
    send_byte(8'hA5);
    for (int i = 0; i < 6; i++) send_byte(w[i*8 +: 8]);
    send_byte(ck);
  endtask

  task automatic check_counts(input string tag);
    n_cmp++;
    if (rec_count !== 16'(exp_rec) || err_count !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL %s_counts: rec=%0d err=%0d, required rec=%0d err=%0d",
               tag, rec_count, err_count, exp_rec, exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; byte_valid = 1'b0; byte_in = 8'h00; rec_ready = 1'b1;
    exp_q.delete(); exp_rec = 0; exp_err = 0;
    #1;
    n_cmp++;
    if (all_outs() !== 80'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", all_outs());
    end
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (byte_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b, required 0", byte_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release: got %b, required 1", byte_ready);
    end
  endtask

  task automatic test_good_record();
    rec_ready = 1'b1;
    send_frame(GOOD_W, 8'h49);
    n_cmp++;
    if (rec_valid !== 1'b1 || time_stamp !== 10'h155 || in_flag !== 1'b1 ||
        method_field !== 2'b10 || value !== 30'h12345678 || new_wallet !== 1'b1) begin
      n_fail++;
      $display("FAIL good_record: valid=%b ts=%h in=%b m=%b v=%h nw=%b, required 1 155 1 10 12345678 1",
               rec_valid, time_stamp, in_flag, method_field, value, new_wallet);
    end
    repeat (3) @(posedge clk); #1;
    check_counts("good");
  endtask

  task automatic test_bad_crc();
    int c0;
    c0 = crc_seen;
    send_frame(GOOD_W, 8'h48);
    repeat (3) @(posedge clk); #1;
    exp_err++;
    n_cmp++;
    if (crc_seen - c0 !== 1) begin
      n_fail++;
      $display("FAIL bad_crc_pulse: pulses=%0d, required 1", crc_seen - c0);
    end
    check_counts("bad_crc");
    send_frame(GOOD_W, 8'h49);
    repeat (3) @(posedge clk); #1;
    check_counts("after_bad_crc");
  endtask

  task automatic test_reserved();
    int c0;
    c0 = crc_seen;
    send_frame(48'h1A468ACF1555, 8'h59);
    repeat (3) @(posedge clk); #1;
    exp_err++;
    n_cmp++;
    if (crc_seen - c0 !== 1) begin
      n_fail++;
      $display("FAIL reserved_pulse: pulses=%0d, required 1", crc_seen - c0);
    end
    check_counts("reserved");
  endtask

  task automatic test_backpressure();
    rec_t e;
    rec_t got;
    e = decode(GOOD_W);
    rec_ready = 1'b0;
    send_frame(GOOD_W, 8'h49);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      got = '{ts: time_stamp, dir: in_flag, m: method_field, v: value, nw: new_wallet};
      n_cmp++;
      if (byte_ready !== 1'b0 || rec_valid !== 1'b1 || got !== e) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: ready=%b valid=%b fields=%h, required 0 1 %h",
                 i, byte_ready, rec_valid, got, e);
      end
    end
    @(posedge clk); #1;
    rec_ready = 1'b1;
    @(posedge clk); #1;
    check_counts("backpressure");
    n_cmp++;
    if (byte_ready !== 1'b1 || rec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL release: ready=%b valid=%b, required 1 0", byte_ready, rec_valid);
    end
  endtask

  task automatic test_timeout();
    int t0;
    t0 = tmo_seen;
    send_byte(8'hA5);
    send_byte(8'h55);
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: got %b, required 0", timeout_err);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_pulse: got %b, required 1", timeout_err);
    end
    @(posedge clk); #1;
    exp_err++;
    n_cmp++;
    if (timeout_err !== 1'b0 || tmo_seen - t0 !== 1) begin
      n_fail++;
      $display("FAIL timeout_once: level=%b pulses=%0d, required 0 1", timeout_err, tmo_seen - t0);
    end
    check_counts("timeout");
    send_frame(GOOD_W, 8'h49);
    repeat (3) @(posedge clk); #1;
    check_counts("after_timeout");
    // Byte landing exactly in the limit cycle must cancel the timeout.
    t0 = tmo_seen;
    exp_q.push_back(decode(GOOD_W));
    exp_rec++;
    send_byte(8'hA5);
    send_byte(8'h55);
    repeat (3) @(posedge clk); #1;
    send_byte(8'h15);
    send_byte(8'hCF);
    send_byte(8'h8A);
    send_byte(8'h46);
    send_byte(8'h0A);
    send_byte(8'h49);
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (tmo_seen - t0 !== 0) begin
      n_fail++;
      $display("FAIL timeout_cancel: pulses=%0d, required 0", tmo_seen - t0);
    end
    check_counts("timeout_cancel");
  endtask

  task automatic test_garbage_sync();
    logic [47:0] w;
    int c0;
    int t0;
    c0 = crc_seen; t0 = tmo_seen;
    w = {8'h09, 8'h78, 8'h56, 8'h34, 8'h12, 8'hA5};
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(w, xsum(w));
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (crc_seen != c0 || tmo_seen != t0) begin
      n_fail++;
      $display("FAIL garbage_errors: crc=%0d tmo=%0d, required 0 0", crc_seen - c0, tmo_seen - t0);
    end
    check_counts("garbage_sync");
  endtask

  task automatic test_reset_mid();
    send_byte(8'hA5);
    send_byte(8'h55);
    send_byte(8'h15);
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (all_outs() !== 80'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h, required 0", all_outs());
    end
    exp_q.delete(); exp_rec = 0; exp_err = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame(GOOD_W, 8'h49);
    repeat (3) @(posedge clk); #1;
    check_counts("reset_mid");
  endtask

  initial begin
    test_reset();
    test_good_record();
    test_bad_crc();
    test_reserved();
    test_backpressure();
    test_timeout();
    test_garbage_sync();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d records outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/transaction_record_deframer.md
Name: transaction_record_deframer

Overview:
Byte-stream front end that assembles serialized transaction records into parallel per-transaction fields for the wallet confidence scorer. It sits between the host byte link and the scorer. It hunts for a sync byte, collects a 6-byte payload, and verifies an XOR checksum. Each good record is then presented through a valid/ready handshake, while malformed or stalled frames are dropped and counted.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 255, max idle cycles between accepted bytes inside a frame before abort (min 1)
CNT_W, 16, width of record/error counters

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
byte_in  input  8  incoming stream byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  deframer can accept a byte
time_stamp  output  10  record timestamp
in  output  1  direction flag (1 = inbound transfer)
method_field  output  2  contract method code
value  output  30  transfer value
new_wallet  output  1  record belongs to a new wallet
rec_valid  output  1  record fields valid
rec_ready  input  1  scorer accepts record
crc_err  output  1  one-cycle pulse: checksum or reserved-bit failure
timeout_err  output  1  one-cycle pulse: inter-byte timeout
rec_count  output  CNT_W  records delivered, saturating
err_count  output  CNT_W  frames dropped (crc+timeout), saturating

Behaviour:
- Frame format, 8 bytes: SYNC_BYTE, payload b0..b5, checksum = b0^b1^b2^b3^b4^b5.
- Payload word W[47:0] = {b5,b4,b3,b2,b1,b0}. Field mapping:
  - W[9:0] time_stamp
  - W[10] in
  - W[12:11] method_field
  - W[42:13] value
  - W[43] new_wallet
  - W[47:44] reserved, must be 0.
- Byte accepted when byte_valid && byte_ready.
- byte_ready is registered. It is 1 in HUNT, PAYLOAD and CHECK, and 0 in OUTPUT.
- Reset (async): state HUNT. All outputs 0, including byte_ready, fields, pulses and counters. byte_ready rises on the first clk edge after rst deasserts.
- FSM:
  - HUNT: accepted bytes != SYNC_BYTE are discarded silently (no error). An accepted SYNC_BYTE moves to PAYLOAD with idx=0, chk=0 and the timeout counter cleared.
  - PAYLOAD: each accepted byte is stored at position idx and chk ^= byte. The 6th byte moves to CHECK. A SYNC_BYTE value here is ordinary payload; it does not resync.
  - CHECK: the accepted byte is compared to chk.
    - Match and W[47:44]==0: latch the fields and go to OUTPUT. rec_valid=1 in the cycle after the checksum byte is accepted.
    - Otherwise: crc_err pulses for 1 cycle, err_count increments, and the FSM returns to HUNT. No record is emitted.
  - OUTPUT: rec_valid=1 and fields are held stable. On rec_valid && rec_ready: rec_count increments, rec_valid=0 next cycle, FSM goes to HUNT, and byte_ready=1 next cycle. No timeout applies in OUTPUT; the FSM waits indefinitely.
- Fields update only on entry to OUTPUT and hold their value otherwise, including after handshake.
- Timeout (PAYLOAD/CHECK only):
  - The counter increments on each cycle with no accepted byte and clears on an accepted byte.
  - When it reaches TIMEOUT_CYCLES: FSM goes to HUNT, timeout_err pulses 1 cycle, err_count increments.
  - If a byte is accepted in the same cycle the count would hit the limit, the byte wins and there is no timeout.
- Counters saturate at all-ones; no wrap.
- crc_err and timeout_err are never simultaneous.
- Minimum record spacing: 8 accepted bytes, plus 1 OUTPUT cycle, plus 1 cycle back to HUNT.

Test Plan:
- Good record: stream A5 55 15 CF 8A 46 0A 49 with rec_ready=1. Required: rec_valid 1 cycle after 0x49 is accepted, time_stamp=0x155, in=1, method_field=2'b10, value=0x12345678, new_wallet=1, rec_count=1, err_count=0.
- Bad checksum: same frame ending 0x48. Required: crc_err pulses once, err_count=1, no rec_valid. A following good frame is delivered normally.
- Reserved bits: payload b5=0x1A with a correctly recomputed checksum 0x59. Required: crc_err, err_count increments, no record.
- Backpressure: rec_ready=0 for 20 cycles after the good frame. Required: byte_ready=0 and fields stable throughout. Raising rec_ready gives rec_count=1, and byte_ready=1 the next cycle.
- Timeout, with TIMEOUT_CYCLES=4: send A5 55, then idle. Required: timeout_err pulses on the 4th idle cycle and the FSM returns to HUNT. A byte arriving exactly on the 4th idle cycle cancels the timeout.
- Garbage, embedded sync, and reset: send 00 FF then a good frame whose payload contains 0xA5. Required: correct record delivered and no errors. Asserting rst mid-payload clears all outputs and counters immediately, and a full frame after release decodes correctly.
